// File: rtl/rni_txflit_sndr_if.sv
// rni_txflit_sndr_if: upstream flit handshake, L-credit sideband, link-deactivation
// handshake and registered link flit outputs of the RNI TX flit sender.
// master = the side that feeds flits and credits, slave = the sender itself.
interface rni_txflit_sndr_if #(
    parameter int unsigned FLIT_WIDTH = 64
);
    logic                  in_valid;
    logic [FLIT_WIDTH-1:0] in_flit;
    logic                  in_ready;
    logic                  lcrd_avail;
    logic                  lcrd_dec;
    logic                  deact_req;
    logic                  deact_done;
    logic                  txflitv;
    logic [FLIT_WIDTH-1:0] txflit;
    logic                  txflit_rtn;

    modport master (
        output in_valid, in_flit, lcrd_avail, deact_req,
        input  in_ready, lcrd_dec, deact_done, txflitv, txflit, txflit_rtn
    );

    modport slave (
        input  in_valid, in_flit, lcrd_avail, deact_req,
        output in_ready, lcrd_dec, deact_done, txflitv, txflit, txflit_rtn
    );
endinterface

// File: rtl/rni_txflit_sndr.sv
// rni_txflit_sndr: buffers upstream flits in a small FIFO and sends one flit per
// available L-credit onto a registered link. On deact_req the block drains its FIFO,
// returns every remaining credit as zero-payload return flits, then parks in STOP
// with deact_done set until deact_req drops.
// Optional feature: define RNI_TXFLIT_BYPASS_EN to let a flit skip the empty FIFO
// in RUN (accept-to-txflitv latency 1 instead of 2).
module rni_txflit_sndr #(
    parameter int unsigned FLIT_WIDTH = 64,
    parameter int unsigned FIFO_DEPTH = 4   // 2, 4 or 8
) (
    input  logic               clk,
    input  logic               rst_n,
    rni_txflit_sndr_if.slave   bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, DRAIN, RETURN, STOP} state_t;

    state_t                state;
    logic [FLIT_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [AW:0]           count;

    logic                  empty;
    logic                  full;
    logic                  send;
    logic                  ret_fire;
    logic                  byp;
    logic                  ready;
    logic                  push;

    logic                  txflitv_q;
    logic [FLIT_WIDTH-1:0] txflit_q;
    logic                  txflit_rtn_q;
    logic                  deact_done_q;

    // Handshake decode: send/return/bypass firing, ready and enqueue, all held off in reset.
    // A full FIFO still accepts when the head is popped in the same cycle.
    always_comb begin
        empty    = (count == '0);
        full     = (count == (AW+1)'(FIFO_DEPTH));
        send     = rst_n && (state == RUN || state == DRAIN) && !empty && bus.lcrd_avail;
        ret_fire = rst_n && (state == RETURN) && bus.lcrd_avail;
        byp      = 1'b0;
`ifdef RNI_TXFLIT_BYPASS_EN
        byp      = rst_n && (state == RUN) && empty && bus.in_valid && bus.lcrd_avail;
`endif
        ready    = rst_n && (state == RUN) && (!full || send);
        push     = bus.in_valid && ready && !byp;
    end

    assign bus.in_ready   = ready;
    assign bus.lcrd_dec   = send || ret_fire || byp;
    assign bus.txflitv    = txflitv_q;
    assign bus.txflit     = txflit_q;
    assign bus.txflit_rtn = txflit_rtn_q;
    assign bus.deact_done = deact_done_q;

    // FIFO storage: payload only, no reset needed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_flit;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at the power-of-two depth.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (send) rd_ptr <= rd_ptr + 1'b1;
            case ({push, send})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Deactivation FSM with registered link outputs and deact_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= RUN;
            txflitv_q    <= 1'b0;
            txflit_q     <= '0;
            txflit_rtn_q <= 1'b0;
            deact_done_q <= 1'b0;
        end else begin
            txflitv_q    <= send || ret_fire || byp;
            txflit_rtn_q <= ret_fire;
            if (send) begin
                txflit_q <= mem[rd_ptr];
            end else if (byp) begin
                txflit_q <= bus.in_flit;
            end else if (ret_fire) begin
                txflit_q <= '0;
            end
            case (state)
                RUN: begin
                    if (bus.deact_req) state <= DRAIN;
                end
                DRAIN: begin
                    // empty now, or the last entry leaves this cycle
                    if (empty || (count == (AW+1)'(1) && send)) state <= RETURN;
                end
                RETURN: begin
                    if (!bus.lcrd_avail) begin
                        state        <= STOP;
                        deact_done_q <= 1'b1;
                    end
                end
                STOP: begin
                    if (!bus.deact_req) begin
                        state        <= RUN;
                        deact_done_q <= 1'b0;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule
